// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Control stage in front of a 2**SEL_W : 1 bit mux. The block steps the mux
//   select lines and samples the mux output, so the mux works as a timed
//   parallel-to-serial scanner. It supports a full scan of every channel or a
//   scan of one channel. Sampled bits are collected in a shadow register. The
//   shadow is copied to `word` in a single update, together with a one-cycle
//   `done` pulse.
//
// Parameters
//   SEL_W   select width; channel count N = 2**SEL_W
//   SETTLE  wait cycles after each select change before sampling (0..15)
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    scan request, accepted only in IDLE
//   single   sampled with start: 1 = scan channel `chan` only, 0 = full scan
//   chan     channel used in single mode, sampled with start
//   mux_bit  output bit of the mux
//   sel      mux select lines
//   busy     high from the accepting edge until DONE exits
//   done     one-cycle pulse when `word` is updated
//   word     published sample word; bit i = sample of channel i
module mux_scan_sequencer #(
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    single,
  input  logic [SEL_W-1:0]        chan,
  input  logic                    mux_bit,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic                    done,
  output logic [(2**SEL_W)-1:0]   word
);

  localparam int N = 2**SEL_W;
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t         state;
  logic           single_q;
  logic [3:0]     cnt;
  logic [N-1:0]   shadow;
  logic [N-1:0]   shadow_nx;

  // The shadow value that includes the bit sampled in this cycle. It feeds
  // the shadow register and, on the last sample, the published word. This
  // lets `word` update on the same edge that enters DONE.
  always_comb begin
    shadow_nx      = shadow;
    shadow_nx[sel] = mux_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      single_q <= 1'b0;
      cnt      <= '0;
      shadow   <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            single_q <= single;
            sel      <= single ? chan : '0;
            busy     <= 1'b1;
            // Single mode rewrites one bit. Start from the current word so
            // the other bits keep their values.
            shadow   <= word;
            cnt      <= '0;
            state    <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_SAMPLE: begin
          shadow <= shadow_nx;
          if (!single_q && (sel != SEL_LAST)) begin
            sel   <= sel + 1'b1;
            cnt   <= '0;
            state <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end else begin
            word  <= shadow_nx;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;

  // Instance A: SETTLE=0
  logic        start_a, single_a;
  logic [3:0]  chan_a, sel_a;
  logic        mux_bit_a, busy_a, done_a;
  logic [15:0] word_a, in_a;

  // Instance B: SETTLE=1
  logic        start_b, single_b;
  logic [3:0]  chan_b, sel_b;
  logic        mux_bit_b, busy_b, done_b;
  logic [15:0] word_b, in_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  always #5 clk = ~clk;

  // 16:1 bit mux behaviour, combinational
  assign mux_bit_a = in_a[sel_a];
  assign mux_bit_b = in_b[sel_b];

  mux_scan_sequencer #(.SEL_W(4), .SETTLE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .single(single_a), .chan(chan_a),
    .mux_bit(mux_bit_a), .sel(sel_a), .busy(busy_a), .done(done_a), .word(word_a)
  );

  mux_scan_sequencer #(.SEL_W(4), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .single(single_b), .chan(chan_b),
    .mux_bit(mux_bit_b), .sel(sel_b), .busy(busy_b), .done(done_b), .word(word_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every done pulse must match a queued expectation
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (exp_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else chk("a_word", word_a, exp_a.pop_front());
    end
    if (done_b === 1'b1) begin
      if (exp_b.size() == 0) chk("b_unexpected_done", 1, 0);
      else chk("b_word", word_b, exp_b.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-channel scan on B; start is accepted at edge 0
  task automatic single_b_scan(input logic [3:0] c, input logic [15:0] exp_word);
    exp_b.push_back(exp_word);
    single_b = 1'b1;
    chan_b   = c;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    chan_b   = ~c;  // changes after accept must have no effect
    single_b = 1'b0;
    chk("b_single_sel", sel_b, c);
    chk("b_single_busy", busy_b, 1);
    tick();
    chk("b_single_settle_nodone", done_b, 0);
    tick();
    chk("b_single_done", done_b, 1);
    tick();
    chk("b_single_busy_low", busy_b, 0);
    chk("b_single_done_low", done_b, 0);
  endtask

  // Full scan on B with optional ignored start pulses and a mid-scan input change
  task automatic full_b_scan(input bit extra, input bit change_in, input logic [15:0] exp_word);
    exp_b.push_back(exp_word);
    single_b = 1'b0;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    chk("b_full_sel0", sel_b, 0);
    for (int e = 1; e <= 32; e++) begin
      start_b = extra && (e == 3 || e == 8);
      tick();
      start_b = 1'b0;
      // ch11 was sampled at edge 24 and ch12 is sampled at edge 26
      if (change_in && e == 24) in_b = 16'hFFFF;
      if (e <= 31 && (e % 4 == 1 || e == 31)) chk("b_full_sel", sel_b, e >> 1);
      if (e == 31) chk("b_full_nodone_early", done_b, 0);
      if (e == 32) chk("b_full_done", done_b, 1);
    end
    tick();
    chk("b_full_busy_low", busy_b, 0);
    in_b = 16'hA5F0;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 0; single_a = 0; chan_a = 0; in_a = 16'hA5F0;
    start_b = 0; single_b = 0; chan_b = 0; in_b = 16'hA5F0;
    tick();
    tick();
    chk("rst_sel_a", sel_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_word_a", word_a, 0);
    chk("rst_word_b", word_b, 0);
    rst = 1'b0;
    tick();

    // 1: full scan, SETTLE=0; start held during DONE is ignored
    exp_a.push_back(16'hA5F0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_sel0", sel_a, 0);
    chk("a_busy", busy_a, 1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("a_sel_step", sel_a, k);
      chk("a_nodone", done_a, 0);
    end
    tick();
    chk("a_done", done_a, 1);
    chk("a_busy_in_done", busy_a, 1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_busy_low", busy_a, 0);
    chk("a_done_low", done_a, 0);
    chk("a_sel_hold", sel_a, 15);
    tick();
    chk("a_start_in_done_ignored", busy_a, 0);

    // 3: single mode on B
    single_b_scan(4'd10, 16'h0400);
    single_b_scan(4'd9, 16'h0400);

    // 2: full scan, SETTLE=1
    full_b_scan(1'b0, 1'b0, 16'hA5F0);
    tick();

    // 4: start pulses during a scan are ignored
    in_b = 16'h0000;
    single_b_scan(4'd8, 16'hA4F0);
    in_b = 16'hA5F0;
    full_b_scan(1'b1, 1'b0, 16'hA5F0);
    tick();

    // 5: async reset mid-scan at sel=5
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    chk("b_sel5", sel_b, 5);
    rst = 1'b1;
    #1;
    chk("b_rst_sel", sel_b, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_word", word_b, 0);
    chk("b_rst_done", done_b, 0);
    tick();
    rst = 1'b0;
    tick();
    full_b_scan(1'b0, 1'b0, 16'hA5F0);
    tick();

    // 6: input change before channel 12 is sampled
    full_b_scan(1'b0, 1'b1, 16'hF5F0);
    tick();
    tick();

    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
